flow_tx_arbiter: RTL
====================

Name: flow_tx_arbiter

Overview:
- Packet-granular weighted round-robin arbiter that shares the single 64-bit AXI-stream TX path into the 10G MAC FIFO between N_FLOWS packet-generator flow sources.
- Each flow is granted the path for up to cfg_weight consecutive whole packets, then the grant rotates to the next flow.
- Never interleaves beats of different packets.
- Sits between the per-flow packet generators and the eth_mac_10g_fifo tx_axis input, in the core logic clock domain.

Parameters:
- DATA_WIDTH, 64, tdata width per stream.
- KEEP_WIDTH, DATA_WIDTH/8, tkeep width.
- N_FLOWS, 2, number of flow sources (2..16).
- WEIGHT_WIDTH, 8, width of each per-flow weight.
- CNT_WIDTH, 32, width of the forwarded-packet counter.

Ports:
- clk  in  1  core clock (156.25 MHz)
- rst_n  in  1  asynchronous active-low reset
- s_axis_tdata  in  N_FLOWS*DATA_WIDTH  flow i occupies slice i
- s_axis_tkeep  in  N_FLOWS*KEEP_WIDTH  per-flow tkeep
- s_axis_tvalid  in  N_FLOWS  per-flow valid
- s_axis_tready  out  N_FLOWS  per-flow ready
- s_axis_tlast  in  N_FLOWS  per-flow last
- m_axis_tdata  out  DATA_WIDTH  to MAC FIFO
- m_axis_tkeep  out  KEEP_WIDTH  to MAC FIFO
- m_axis_tvalid  out  1  to MAC FIFO
- m_axis_tready  in  1  from MAC FIFO
- m_axis_tlast  out  1  to MAC FIFO
- cfg_flow_enable  in  N_FLOWS  per-flow enable
- cfg_weight  in  N_FLOWS*WEIGHT_WIDTH  packets per turn; 0 means flow never granted
- grant_id  out  clog2(N_FLOWS) (min 1)  flow currently/last granted
- busy  out  1  high in XFER
- pkt_count  out  CNT_WIDTH  total packets forwarded

Behaviour:
- Reset values (rst_n low, asynchronous, effective immediately):
  - state=IDLE, ptr=0, turn_cnt=0, grant_id=0, pkt_count=0.
  - m_axis_tvalid=0, s_axis_tready=0, busy=0.
- Eligibility of flow i: cfg_flow_enable[i] & (cfg_weight[i]!=0) & s_axis_tvalid[i].
- State IDLE:
  - m_axis_tvalid=0 and all s_axis_tready=0.
  - Search flows starting at ptr, ascending and wrapping modulo N_FLOWS, for the first eligible flow g.
  - If g found: grant_id<=g and state<=XFER on the next edge. Arbitration latency is 1 cycle from eligible valid to m_axis_tvalid.
  - If g!=ptr, turn_cnt<=0 (new turn).
  - If none eligible, stay in IDLE.
- State XFER:
  - Combinational pass-through: m_axis_{tdata,tkeep,tvalid,tlast} = flow g's signals.
  - s_axis_tready[g] = m_axis_tready; all other s_axis_tready = 0.
  - busy=1.
- End of packet: when a beat is accepted with tlast=1 (m_axis_tvalid & m_axis_tready & m_axis_tlast):
  - pkt_count increments; it wraps at 2^CNT_WIDTH.
  - If turn_cnt+1 < cfg_weight[g]: turn_cnt<=turn_cnt+1 and ptr<=g (flow g keeps priority).
  - Otherwise: turn_cnt<=0 and ptr<=(g+1) mod N_FLOWS.
  - state<=IDLE. There is always at least one idle cycle between packets.
- Config sampling: cfg_flow_enable and cfg_weight are sampled only in IDLE and at end-of-packet.
  - Disabling flow g or zeroing its weight mid-packet does not truncate the packet. The packet completes, then the flow is skipped.
- Backpressure: with m_axis_tready=0, the state holds and the beat stays on m_axis. Source tvalid drop mid-packet is passed through unchanged (bubble); the grant is held until tlast.
- Simultaneous events: tlast acceptance and new eligibility of other flows resolve in the following IDLE cycle using the updated ptr.
- Turn limit: turn_cnt width is WEIGHT_WIDTH. Weight 255 allows 255 back-to-back packets per turn.
- Reset mid-packet: all outputs drop immediately. The downstream MAC FIFO is responsible for discarding the partial frame.

Test Plan:
- Reset: rst_n=0 while flow 0 mid-packet -> m_axis_tvalid=0, s_axis_tready=0, pkt_count=0, grant_id=0 within the same cycle. After release with nothing valid -> IDLE.
- Equal weights: N_FLOWS=2, weights 1/1, both flows continuously sending 3-beat packets, tready=1 -> output order flow0, flow1, flow0, flow1. Each packet is 3 beats plus 1 idle cycle. pkt_count=4 after 4 packets.
- Weighted: weights 3/1, both saturated -> output sequence 0,0,0,1,0,0,0,1. After 8 packets pkt_count=8 and turn_cnt=0.
- Weight 0 / disable: cfg_weight[1]=0, or cfg_flow_enable[1] cleared mid-packet of flow 1 -> current flow-1 packet completes intact; afterwards only flow 0 is granted, s_axis_tready[1] stays 0.
- Backpressure and bubbles: m_axis_tready toggling 1,0,1,0 and flow 0 tvalid gapped mid-packet -> every beat delivered exactly once in order with tdata/tkeep/tlast unchanged, and flow 1 is never granted until flow 0's tlast.
- Counter wrap: CNT_WIDTH=4, 17 packets -> pkt_count=1.

Source files
------------

// File: rtl/flow_tx_arbiter_if.sv
// rtl/flow_tx_arbiter_if.sv - per-flow source streams and merged MAC TX stream bundle
interface flow_tx_arbiter_if #(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int N_FLOWS    = 2
);
    logic [N_FLOWS*DATA_WIDTH-1:0] s_axis_tdata;
    logic [N_FLOWS*KEEP_WIDTH-1:0] s_axis_tkeep;
    logic [N_FLOWS-1:0]            s_axis_tvalid;
    logic [N_FLOWS-1:0]            s_axis_tready;
    logic [N_FLOWS-1:0]            s_axis_tlast;

    logic [DATA_WIDTH-1:0]         m_axis_tdata;
    logic [KEEP_WIDTH-1:0]         m_axis_tkeep;
    logic                          m_axis_tvalid;
    logic                          m_axis_tready;
    logic                          m_axis_tlast;

    // Arbiter side: consumes flow streams, produces the MAC stream.
    modport slave (
        input  s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        output s_axis_tready, m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast
    );

    modport master (
        output s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        input  s_axis_tready, m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast
    );
endinterface

// File: rtl/flow_tx_arbiter.sv
// rtl/flow_tx_arbiter.sv - packet-granular weighted round-robin arbiter for the 10G MAC TX stream
module flow_tx_arbiter #(
    parameter int  DATA_WIDTH   = 64,
    parameter int  KEEP_WIDTH   = DATA_WIDTH / 8,
    parameter int  N_FLOWS      = 2,
    parameter int  WEIGHT_WIDTH = 8,
    parameter int  CNT_WIDTH    = 32,
    localparam int GW           = (N_FLOWS > 1) ? $clog2(N_FLOWS) : 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    flow_tx_arbiter_if.slave                axis,
    input  logic [N_FLOWS-1:0]              cfg_flow_enable,
    input  logic [N_FLOWS*WEIGHT_WIDTH-1:0] cfg_weight,
    output logic [GW-1:0]                   grant_id,
    output logic                            busy,
    output logic [CNT_WIDTH-1:0]            pkt_count
);

    localparam logic [0:0]    ST_IDLE   = 1'b0;
    localparam logic [0:0]    ST_XFER   = 1'b1;
    localparam logic [GW-1:0] LAST_FLOW = GW'(N_FLOWS - 1);

    logic [0:0]              state;
    logic [GW-1:0]           ptr;
    logic [WEIGHT_WIDTH-1:0] turn_cnt;

    logic [DATA_WIDTH-1:0]   flow_tdata  [N_FLOWS];
    logic [KEEP_WIDTH-1:0]   flow_tkeep  [N_FLOWS];
    logic [WEIGHT_WIDTH-1:0] flow_weight [N_FLOWS];
    logic [N_FLOWS-1:0]      eligible;

    genvar gi;
    generate
        for (gi = 0; gi < N_FLOWS; gi++) begin : g_unpack
            assign flow_tdata[gi]  = axis.s_axis_tdata[gi*DATA_WIDTH +: DATA_WIDTH];
            assign flow_tkeep[gi]  = axis.s_axis_tkeep[gi*KEEP_WIDTH +: KEEP_WIDTH];
            assign flow_weight[gi] = cfg_weight[gi*WEIGHT_WIDTH +: WEIGHT_WIDTH];
            assign eligible[gi]    = cfg_flow_enable[gi] & (flow_weight[gi] != '0)
                                   & axis.s_axis_tvalid[gi];
        end
    endgenerate

    // Rotate eligibility so bit 0 is the flow at ptr; lowest set bit wins.
    logic [2*N_FLOWS-1:0] elig_rot;
    logic                 found;
    logic [GW-1:0]        pick;
    int                   pick_idx;

    always_comb begin
        elig_rot = {eligible, eligible} >> ptr;
        found    = 1'b0;
        pick_idx = 0;
        for (int k = N_FLOWS - 1; k >= 0; k--) begin
            if (elig_rot[k]) begin
                found    = 1'b1;
                pick_idx = int'(ptr) + k;
            end
        end
        if (pick_idx >= N_FLOWS) begin
            pick_idx = pick_idx - N_FLOWS;
        end
        pick = GW'(pick_idx);
    end

    logic xfer;
    assign xfer = (state == ST_XFER);
    assign busy = xfer;

    assign axis.m_axis_tdata  = flow_tdata[grant_id];
    assign axis.m_axis_tkeep  = flow_tkeep[grant_id];
    assign axis.m_axis_tlast  = axis.s_axis_tlast[grant_id];
    assign axis.m_axis_tvalid = xfer & axis.s_axis_tvalid[grant_id];

    always_comb begin
        axis.s_axis_tready = '0;
        if (xfer) begin
            axis.s_axis_tready[grant_id] = axis.m_axis_tready;
        end
    end

    logic                  eop;
    logic [WEIGHT_WIDTH:0] turn_next;
    logic [WEIGHT_WIDTH:0] cur_weight;

    assign eop        = xfer & axis.m_axis_tvalid & axis.m_axis_tready & axis.m_axis_tlast;
    assign turn_next  = {1'b0, turn_cnt} + (WEIGHT_WIDTH + 1)'(1);
    assign cur_weight = {1'b0, flow_weight[grant_id]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            turn_cnt  <= '0;
            grant_id  <= '0;
            pkt_count <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        grant_id <= pick;
                        state    <= ST_XFER;
                        if (pick != ptr) begin
                            turn_cnt <= '0;
                        end
                    end
                end
                ST_XFER: begin
                    // Weight is re-read at end of packet so a mid-turn change takes effect now.
                    if (eop) begin
                        pkt_count <= pkt_count + CNT_WIDTH'(1);
                        state     <= ST_IDLE;
                        if (turn_next < cur_weight) begin
                            turn_cnt <= turn_next[WEIGHT_WIDTH-1:0];
                            ptr      <= grant_id;
                        end else begin
                            turn_cnt <= '0;
                            ptr      <= (grant_id == LAST_FLOW) ? '0 : grant_id + GW'(1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
